// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
// Holds the SQI widths, memory indices, controller states and command bytes.
package idli_pkg;

    localparam int unsigned SQI_NUM = 2;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic {
        SQI_MEM_LO = 1'b0,
        SQI_MEM_HI = 1'b1
    } sqi_mem_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4
    } sqi_state_t;

    localparam logic [7:0] SQI_CMD_READ     = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE    = 8'h02;
    localparam logic [2:0] SQI_ADDR_NIBBLES = 3'd6;

    // Command byte for a read or write transaction.
    function automatic logic [7:0] sqi_cmd(input logic wr);
        return wr ? SQI_CMD_WRITE : SQI_CMD_READ;
    endfunction

endpackage

// File: rtl/idli_sqi_shift.sv
// Command/address shifter shared by both SQI memories.
// o_nibble is the nibble to present on the pins in the following cycle.
module idli_sqi_shift
    import idli_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_load_data,
    input  logic        i_shift,
    output sqi_data_t   o_nibble
);

    logic [31:0] sh_r;

    // The top nibble leaves straight from the load data, so only the rest is stored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_r <= 32'h0000_0000;
        end else if (i_load) begin
            sh_r <= {i_load_data[27:0], 4'h0};
        end else if (i_shift) begin
            sh_r <= {sh_r[27:0], 4'h0};
        end else begin
            sh_r <= sh_r;
        end
    end

    assign o_nibble = i_load ? i_load_data[31:28] : sh_r[31:28];

endmodule

// File: rtl/idli_sqi_ctrl.sv
// Nibble-serial SQI controller driving two lockstep memories (lo/hi nibble).
// Turns word read/write bursts into command, address, dummy and data phases.
module idli_sqi_ctrl
    import idli_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_vld,
    output logic                       o_req_rdy,
    input  logic                       i_req_wr,
    input  logic [15:0]                i_req_addr,
    input  logic                       i_end,
    output logic                       o_rd_vld,
    output logic [7:0]                 o_rd_data,
    output logic                       o_wr_rdy,
    input  logic [7:0]                 i_wr_data,
    output logic                       o_sqi_cs_n,
    output logic                       o_sqi_sck_en,
    output logic                       o_sqi_oe,
    output sqi_data_t [SQI_NUM-1:0]    o_sqi_dout,
    input  sqi_data_t [SQI_NUM-1:0]    i_sqi_din
);

    sqi_state_t                state_r, state_s;
    logic [2:0]                phase_r, phase_s;
    logic                      wr_r, wr_s;
    logic                      end_r, end_s;
    logic                      req_rdy_r;
    logic                      rd_vld_r;
    logic [7:0]                rd_data_r;
    logic                      wr_rdy_r, wr_rdy_s;
    logic                      cs_n_r;
    logic                      sck_en_r;
    logic                      oe_r, oe_s;
    sqi_data_t [SQI_NUM-1:0]   dout_r, dout_s;
    logic                      accept_s;
    logic                      shift_s;
    logic                      last_addr_s;
    sqi_data_t                 nibble_s;

    idli_sqi_shift u_shift (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (accept_s),
        .i_load_data ({sqi_cmd(i_req_wr), 8'h00, i_req_addr}),
        .i_shift     (shift_s),
        .o_nibble    (nibble_s)
    );

    // Next state, phase and the values the pin registers take next cycle.
    always_comb begin
        accept_s    = (state_r == IDLE) && req_rdy_r && i_req_vld;
        last_addr_s = (phase_r == SQI_ADDR_NIBBLES - 3'd1);
        state_s     = state_r;
        phase_s     = phase_r;
        wr_s        = wr_r;
        end_s       = end_r;
        wr_rdy_s    = 1'b0;
        shift_s     = 1'b0;
        dout_s      = {SQI_NUM{4'h0}};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = CMD;
                    phase_s = 3'd0;
                    wr_s    = i_req_wr;
                    end_s   = 1'b0;
                    dout_s  = {SQI_NUM{nibble_s}};
                end else begin
                    state_s = IDLE;
                end
            end
            CMD: begin
                shift_s = 1'b1;
                dout_s  = {SQI_NUM{nibble_s}};
                if (phase_r == 3'd1) begin
                    state_s = ADDR;
                    phase_s = 3'd0;
                end else begin
                    phase_s = phase_r + 3'd1;
                end
            end
            ADDR: begin
                shift_s = 1'b1;
                if (last_addr_s) begin
                    phase_s = 3'd0;
                    if (wr_r) begin
                        state_s                = DATA;
                        wr_rdy_s               = 1'b1;
                        dout_s[SQI_MEM_HI]     = i_wr_data[7:4];
                        dout_s[SQI_MEM_LO]     = i_wr_data[3:0];
                    end else begin
                        state_s = DUMMY;
                    end
                end else begin
                    phase_s  = phase_r + 3'd1;
                    dout_s   = {SQI_NUM{nibble_s}};
                    // First write byte is requested one cycle before the address ends.
                    wr_rdy_s = wr_r && (phase_r == SQI_ADDR_NIBBLES - 3'd2);
                end
            end
            DUMMY: begin
                if (phase_r == 3'd1) begin
                    state_s = DATA;
                    phase_s = 3'd0;
                end else begin
                    phase_s = phase_r + 3'd1;
                end
            end
            DATA: begin
                if (wr_r) begin
                    dout_s[SQI_MEM_HI] = i_wr_data[7:4];
                    dout_s[SQI_MEM_LO] = i_wr_data[3:0];
                    if (phase_r == 3'd0) begin
                        // Byte 1 of the word is being consumed now, so i_end belongs to it.
                        phase_s  = 3'd1;
                        end_s    = i_end;
                        wr_rdy_s = !i_end;
                    end else begin
                        phase_s = 3'd0;
                        if (end_r) begin
                            state_s = IDLE;
                        end else begin
                            wr_rdy_s = 1'b1;
                        end
                    end
                end else begin
                    if (phase_r == 3'd0) begin
                        phase_s = 3'd1;
                    end else begin
                        phase_s = 3'd0;
                        if (i_end) begin
                            state_s = IDLE;
                        end else begin
                            state_s = DATA;
                        end
                    end
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = 3'd0;
            end
        endcase
        oe_s = (state_s == CMD) || (state_s == ADDR) || ((state_s == DATA) && wr_s);
    end

    // Control state and every registered output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            phase_r   <= 3'd0;
            wr_r      <= 1'b0;
            end_r     <= 1'b0;
            req_rdy_r <= 1'b0;
            cs_n_r    <= 1'b1;
            sck_en_r  <= 1'b0;
            oe_r      <= 1'b0;
            dout_r    <= {SQI_NUM{4'h0}};
            wr_rdy_r  <= 1'b0;
            rd_vld_r  <= 1'b0;
            rd_data_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            phase_r   <= phase_s;
            wr_r      <= wr_s;
            end_r     <= end_s;
            // Ready only after a full IDLE cycle, which keeps CS high between bursts.
            req_rdy_r <= (state_r == IDLE) && !accept_s;
            cs_n_r    <= (state_s == IDLE);
            sck_en_r  <= (state_s != IDLE);
            oe_r      <= oe_s;
            dout_r    <= dout_s;
            wr_rdy_r  <= wr_rdy_s;
            rd_vld_r  <= (state_r == DATA) && !wr_r;
            if ((state_r == DATA) && !wr_r) begin
                rd_data_r <= {i_sqi_din[SQI_MEM_HI], i_sqi_din[SQI_MEM_LO]};
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign o_req_rdy    = req_rdy_r;
    assign o_rd_vld     = rd_vld_r;
    assign o_rd_data    = rd_data_r;
    assign o_wr_rdy     = wr_rdy_r;
    assign o_sqi_cs_n   = cs_n_r;
    assign o_sqi_sck_en = sck_en_r;
    assign o_sqi_oe     = oe_r;
    assign o_sqi_dout   = dout_r;

endmodule
